tx_frame_arbiter: RTL and testbench
===================================

Name: tx_frame_arbiter

Overview:
- Frame-granular round-robin arbiter that shares one transmit FIFO, the one feeding the SNI transmitter, between N_SRC ingress source FIFOs in the L2 switch.
- Once a source is granted, it keeps the grant until its frame's EOD-flagged byte is moved. Frames are never interleaved.
- Enforces a maximum frame length. Over-length frames are truncated with a forced EOD, and their remaining bytes are drained and discarded.
- Sits between the per-port ingress queues and the transmit FIFO write side.

Parameters:
- N_SRC, 4, number of source FIFOs (2..8).
- MAX_LEN, 1518, maximum bytes written per frame, EOD byte included.
- LEN_W, 11, width of the byte counter; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- src_empty  in  N_SRC  per-source FIFO empty.
- src_dout  in  8*N_SRC  per-source byte; source i uses bits [8i+7:8i]; first-word-fall-through, valid while ~src_empty[i].
- src_eod  in  N_SRC  EOD flag accompanying src_dout[i]; marks the last byte of a frame.
- src_rden  out  N_SRC  per-source pop; combinational, at most one bit high.
- txf_afull  in  1  transmit FIFO almost-full.
- txf_din  out  8  byte written to the transmit FIFO.
- txf_eod_in  out  1  EOD flag written alongside txf_din.
- txf_wren  out  1  transmit FIFO write strobe.
- grant_valid  out  1  high while a source holds the grant (XFER or DRAIN).
- grant_idx  out  3  index of the granted source.
- trunc_pulse  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; rr_ptr=N_SRC-1, so source 0 wins first.
  - txf_wren=0, txf_din=0, txf_eod_in=0, grant_valid=0, grant_idx=0, trunc_pulse=0, byte count=0.
  - src_rden=0 whenever state is IDLE.
  - Reset mid-frame abandons the frame. No cleanup writes are generated.
- IDLE:
  - req[i] = ~src_empty[i].
  - If any req is set, select the first set req searching rr_ptr+1, rr_ptr+2, … with wrap modulo N_SRC.
  - Register grant_idx, set rr_ptr=grant_idx, clear byte count, and go to XFER.
  - Arbitration costs 1 cycle. No pop occurs in IDLE.
- XFER:
  - pop = ~src_empty[g] & ~txf_afull, where g = grant_idx. src_rden[g] = pop.
  - Registered write, 1-cycle latency: on pop, the next cycle has txf_wren=1, txf_din=src_dout[g], txf_eod_in=src_eod[g] | force.
  - On pop, the byte count increments.
  - force = (count == MAX_LEN-1) & ~src_eod[g].
  - Pop with src_eod[g]=1: go to IDLE; grant released.
  - Pop with force=1: write the byte with EOD=1, trunc_pulse=1 on the write cycle, go to DRAIN.
  - If the source is empty mid-frame, stall indefinitely holding the grant; frames are never split.
  - If txf_afull is high, stall; no pop, no write.
- DRAIN:
  - src_rden[g] = ~src_empty[g], regardless of txf_afull. No writes.
  - On a pop with src_eod[g]=1, go to IDLE.
- Per-cycle output rules:
  - txf_wren is low in every cycle not following an XFER pop.
  - Back-to-back pops give a continuous write stream.
- Count arithmetic: LEN_W bits, unsigned. It never exceeds MAX_LEN, so there is no wrap.
- Simultaneous events: a new request arriving while a grant is held waits for the next IDLE. The source just served has the lowest priority next round.
- An illegal state encoding recovers to IDLE with all pops low.

Decomposition:
- Shared package tx_sw_pkg holds:
  - the state encoding (IDLE=2'b00, XFER=2'b01, DRAIN=2'b10);
  - MAX_LEN_DEFAULT=1518;
  - the EOD bit position convention used by every FIFO wrapper.
- One natural sub-module, rr_pick: combinational round-robin priority select taking req and rr_ptr, returning a one-hot grant and an index. It is reusable by the RX-side arbiter.

Test Plan:
- Reset, then source 0 holds 3 bytes 0xA1,0xA2,0xA3 with EOD on 0xA3, txf_afull=0 → grant_idx=0; writes A1,A2,A3 on 3 consecutive cycles starting 2 cycles after req; txf_eod_in=1 only with A3; back to IDLE.
- All 4 sources each hold a 2-byte frame → grant order 0,1,2,3; no interleaving of bytes; then source 0 requests again → granted after source 3.
- txf_afull asserted for 5 cycles mid-frame on source 2 → src_rden and txf_wren low for exactly those cycles; byte order preserved.
- MAX_LEN=4, source 1 frame of 7 bytes 0x10..0x16 → writes 0x10..0x13, EOD with 0x13, trunc_pulse once; 0x14..0x16 popped with no write; next grant proceeds normally.
- Source 3 empties after 2 of 4 bytes for 10 cycles while source 0 requests → grant stays on 3; remaining bytes written when refilled; then source 0 granted.
- reset pulsed during an XFER → all outputs 0 immediately (asynchronous); after release the next grant goes to the lowest-index requesting source.

Source files
------------

// File: rtl/tx_sw_pkg.sv
// Shared definitions for the L2 switch transmit path.
// Holds the arbiter state encoding, the default maximum frame length and the
// {eod, byte} word layout used by every source/transmit FIFO wrapper.
package tx_sw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_XFER  = 2'b01,
    ST_DRAIN = 2'b10
  } arb_state_t;

  localparam int MAX_LEN_DEFAULT = 1518;

  // FIFO words are {eod, byte}: the EOD flag sits directly above the data byte.
  localparam int FIFO_DAT_W   = 8;
  localparam int FIFO_EOD_BIT = 8;
  localparam int FIFO_WORD_W  = 9;

  // Width of source indices on every arbiter port (enough for 8 sources).
  localparam int IDX_W = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: the first requester after i_ptr wins,
// wrapping modulo N. Also used by the RX-side arbiter.
// Ports: i_req (requests), i_ptr (last served), o_gnt (one-hot), o_idx (winner).
module rr_pick
  import tx_sw_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_sh;
  logic [N-1:0]   w_rot;
  logic           w_any;
  int             w_off;

  // Rotate the request vector so that bit 0 is the source just after i_ptr;
  // the lowest set bit of the rotated vector is then the winner's distance.
  always_comb begin
    w_dbl = {i_req, i_req};
    w_sh  = w_dbl >> ({1'b0, i_ptr} + 4'd1);
    w_rot = w_sh[N-1:0];
    w_any = |w_rot;
    w_off = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = j;
    end
    o_idx = w_any ? IDX_W'((int'(i_ptr) + 1 + w_off) % N) : '0;
    o_gnt = '0;
    for (int i = 0; i < N; i++) begin
      o_gnt[i] = w_any && (o_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the SNI transmit FIFO from N_SRC
// ingress FIFOs; a grant is held until the frame's EOD byte moves, and frames
// longer than MAX_LEN are cut with a forced EOD and the rest drained.
// Ports: src_* (FWFT source FIFOs, src_rden pops), txf_* (transmit FIFO
// write side, 1-cycle registered write), grant_valid/grant_idx, trunc_pulse.
module tx_frame_arbiter
  import tx_sw_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int MAX_LEN = MAX_LEN_DEFAULT,
  parameter int LEN_W   = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   src_empty,
  input  logic [8*N_SRC-1:0] src_dout,
  input  logic [N_SRC-1:0]   src_eod,
  output logic [N_SRC-1:0]   src_rden,
  input  logic               txf_afull,
  output logic [7:0]         txf_din,
  output logic               txf_eod_in,
  output logic               txf_wren,
  output logic               grant_valid,
  output logic [2:0]         grant_idx,
  output logic               trunc_pulse
);

  localparam logic [LEN_W-1:0] LAST_CNT = LEN_W'(MAX_LEN - 1);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_gidx;
  logic [LEN_W-1:0] r_cnt;
  logic             r_wren;
  logic [7:0]       r_din;
  logic             r_eod;
  logic             r_trunc;

  logic [N_SRC-1:0] w_pick_gnt;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_any;
  logic [7:0]       w_cur_dat;
  logic             w_cur_eod;
  logic             w_cur_empty;
  logic             w_pop_x;
  logic             w_pop_d;
  logic             w_force;

  rr_pick #(.N(N_SRC)) u_pick (
    .i_req (~src_empty),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  assign w_any = |w_pick_gnt;

  // Select the granted source's FWFT head.
  always_comb begin
    w_cur_dat   = '0;
    w_cur_eod   = 1'b0;
    w_cur_empty = 1'b1;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_gidx == IDX_W'(i)) begin
        w_cur_dat   = src_dout[8*i +: 8];
        w_cur_eod   = src_eod[i];
        w_cur_empty = src_empty[i];
      end
    end
  end

  // Draining ignores txf_afull because nothing is written to the TX FIFO.
  assign w_pop_x = (r_state == ST_XFER)  && !w_cur_empty && !txf_afull;
  assign w_pop_d = (r_state == ST_DRAIN) && !w_cur_empty;
  // The MAX_LEN-th byte becomes the frame's last unless it already is.
  assign w_force = (r_cnt == LAST_CNT) && !w_cur_eod;

  always_comb begin
    src_rden = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_rden[i] = (w_pop_x || w_pop_d) && (r_gidx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= IDX_W'(N_SRC - 1);
      r_gidx   <= '0;
      r_cnt    <= '0;
      r_wren   <= 1'b0;
      r_din    <= '0;
      r_eod    <= 1'b0;
      r_trunc  <= 1'b0;
    end else begin
      r_wren  <= 1'b0;
      r_trunc <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gidx   <= w_pick_idx;
            r_rr_ptr <= w_pick_idx;
            r_cnt    <= '0;
            r_state  <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_pop_x) begin
            r_wren <= 1'b1;
            r_din  <= w_cur_dat;
            r_eod  <= w_cur_eod || w_force;
            r_cnt  <= r_cnt + LEN_W'(1);
            if (w_cur_eod) begin
              r_state <= ST_IDLE;
            end else if (w_force) begin
              r_trunc <= 1'b1;
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_pop_d && w_cur_eod) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign txf_wren    = r_wren;
  assign txf_din     = r_din;
  assign txf_eod_in  = r_eod;
  assign trunc_pulse = r_trunc;
  assign grant_valid = (r_state == ST_XFER) || (r_state == ST_DRAIN);
  assign grant_idx   = r_gidx;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter (N_SRC=4, MAX_LEN=4): FWFT source FIFO models,
// a frame-level reference model with a per-cycle compare process, and
// directed scenarios with literal expectations.
module tb_tx_frame_arbiter;

  localparam int N  = 4;
  localparam int ML = 4;

  typedef logic [8:0] q9_t [$];

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   src_empty;
  logic [8*N-1:0] src_dout;
  logic [N-1:0]   src_eod;
  logic [N-1:0]   src_rden;
  logic           txf_afull;
  logic [7:0]     txf_din;
  logic           txf_eod_in;
  logic           txf_wren;
  logic           grant_valid;
  logic [2:0]     grant_idx;
  logic           trunc_pulse;

  tx_frame_arbiter #(.N_SRC(N), .MAX_LEN(ML), .LEN_W(11)) dut (
    .clk         (clk),
    .reset       (reset),
    .src_empty   (src_empty),
    .src_dout    (src_dout),
    .src_eod     (src_eod),
    .src_rden    (src_rden),
    .txf_afull   (txf_afull),
    .txf_din     (txf_din),
    .txf_eod_in  (txf_eod_in),
    .txf_wren    (txf_wren),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .trunc_pulse (trunc_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  q9_t        src_q   [N];   // contents of each source FIFO
  q9_t        model_q [N];   // frames each source is expected to deliver
  logic [9:0] exp_q [$];     // {trunc, eod, byte} expected TX writes
  int         last_srv;      // model: last source served
  int         glog [$];
  int         wlog_dat [$];
  int         wlog_eod [$];
  int         wlog_cyc [$];
  int         ntrunc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      src_empty[i] = (src_q[i].size() == 0);
      if (src_q[i].size() != 0) begin
        src_dout[8*i +: 8] = src_q[i][0][7:0];
        src_eod[i]         = src_q[i][0][8];
      end else begin
        src_dout[8*i +: 8] = 8'h00;
        src_eod[i]         = 1'b0;
      end
    end
  endtask

  // Frame of len bytes base, base+1, ...; the first n_now bytes enter the
  // source FIFO immediately, the rest via src_push later.
  task automatic push_frame(input int s, input int base, input int len, input int n_now);
    for (int k = 0; k < len; k++) begin
      logic [8:0] w;
      w = {(k == len - 1), 8'(base + k)};
      model_q[s].push_back(w);
      if (k < n_now) src_q[s].push_back(w);
    end
    refresh();
  endtask

  task automatic src_push(input int s, input int d, input logic e);
    src_q[s].push_back({e, 8'(d)});
    refresh();
  endtask

  function automatic int rr_next(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic bit all_idle();
    bit r;
    r = (exp_q.size() == 0) && !grant_valid;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0 || model_q[i].size() != 0) r = 0;
    end
    return r;
  endfunction

  // FIFO side: a pop seen in a cycle removes the head after that cycle's edge.
  initial begin : src_model
    logic [N-1:0] pops;
    forever begin
      @(negedge clk);
      pops = src_rden;
      @(posedge clk);
      if (reset) pops = '0;
      #1;
      for (int i = 0; i < N; i++) begin
        if (pops[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      end
      refresh();
    end
  end

  // Per-cycle compare against the frame-level model.
  logic         prev_gv;
  logic [N-1:0] prev_req;
  initial begin : compare
    logic [9:0] e;
    logic [8:0] w;
    int         exp_g;
    int         n;
    prev_gv  = 1'b0;
    prev_req = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_gv  = 1'b0;
        prev_req = ~src_empty;
      end else begin
        chk("rden_legal",
            int'(src_rden != '0 && (!grant_valid || src_rden != (4'b0001 << grant_idx)
                 || (src_rden & src_empty) != '0)), 0);
        if (grant_valid && !prev_gv) begin
          exp_g = rr_next(prev_req, last_srv);
          chk("grant_idx", int'(grant_idx), exp_g);
          glog.push_back(int'(grant_idx));
          last_srv = int'(grant_idx);
          chk("grant_has_frame", int'(model_q[grant_idx].size() != 0), 1);
          n = 0;
          while (model_q[grant_idx].size() != 0) begin
            w = model_q[grant_idx].pop_front();
            n++;
            if (n <= ML)
              exp_q.push_back({(n == ML) && !w[8], w[8] || (n == ML), w[7:0]});
            if (w[8]) break;
          end
        end
        if (!txf_wren) begin
          chk("trunc_idle", int'(trunc_pulse), 0);
        end else begin
          chk("write_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("txf_din", int'(txf_din), int'(e[7:0]));
            chk("txf_eod_in", int'(txf_eod_in), int'(e[8]));
            chk("trunc_pulse", int'(trunc_pulse), int'(e[9]));
          end
          wlog_dat.push_back(int'(txf_din));
          wlog_eod.push_back(int'(txf_eod_in));
          wlog_cyc.push_back(cyc);
          if (trunc_pulse) ntrunc++;
        end
        prev_gv  = grant_valid;
        prev_req = ~src_empty;
      end
    end
  end

  task automatic clear_logs();
    glog.delete();
    wlog_dat.delete();
    wlog_eod.delete();
    wlog_cyc.delete();
    ntrunc = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_wren", int'(txf_wren), 0);
    chk("rst_din", int'(txf_din), 0);
    chk("rst_eod", int'(txf_eod_in), 0);
    chk("rst_gvalid", int'(grant_valid), 0);
    chk("rst_gidx", int'(grant_idx), 0);
    chk("rst_trunc", int'(trunc_pulse), 0);
    chk("rst_rden", int'(src_rden), 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check_reset_outputs();
    exp_q.delete();
    last_srv = N - 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !all_idle()) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(name, int'(all_idle()), 1);
  endtask

  task automatic wait_writes(input string name, input int cnt, input int budget);
    int n;
    n = 0;
    while (n < budget && wlog_dat.size() < cnt) begin
      @(posedge clk);
      n++;
    end
    chk(name, int'(wlog_dat.size() >= cnt), 1);
  endtask

  task automatic chk_glog(input string name, input int exp_list [$]);
    chk(name, glog.size(), exp_list.size());
    for (int k = 0; k < exp_list.size(); k++)
      if (k < glog.size()) chk(name, glog[k], exp_list[k]);
  endtask

  task automatic chk_wdat(input string name, input int exp_list [$]);
    chk(name, wlog_dat.size(), exp_list.size());
    for (int k = 0; k < exp_list.size(); k++)
      if (k < wlog_dat.size()) chk(name, wlog_dat[k], exp_list[k]);
  endtask

  initial begin : watchdog
    #300000;
    errors++;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : main
    int p;
    int n;
    reset     = 1'b1;
    txf_afull = 1'b0;
    last_srv  = N - 1;
    ntrunc    = 0;
    refresh();
    #1;
    check_reset_outputs();
    apply_reset();

    // 1: single 3-byte frame on source 0, written 2..4 cycles after request.
    clear_logs();
    @(posedge clk); #1;
    p = cyc;
    push_frame(0, 'hA1, 3, 3);
    wait_done("t1_done", 40);
    chk_glog("t1_grant", '{0});
    chk_wdat("t1_data", '{'hA1, 'hA2, 'hA3});
    for (int k = 0; k < 3; k++) begin
      if (k < wlog_cyc.size()) begin
        chk("t1_latency", wlog_cyc[k] - p, 2 + k);
        chk("t1_eod", wlog_eod[k], int'(k == 2));
      end
    end

    // 2: all four sources, then source 0 again while source 1 is served.
    apply_reset();
    clear_logs();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) push_frame(i, 'h20 + 2 * i, 2, 2);
    n = 0;
    while (n < 50 && glog.size() < 2) begin
      @(posedge clk); n++;
    end
    chk("t2_second_grant", int'(glog.size() >= 2), 1);
    #1;
    push_frame(0, 'h28, 2, 2);
    wait_done("t2_done", 80);
    chk_glog("t2_order", '{0, 1, 2, 3, 0});
    chk_wdat("t2_data", '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h28, 'h29});

    // 3: txf_afull for 5 cycles after two pops on source 2.
    clear_logs();
    @(posedge clk); #1;
    push_frame(2, 'h30, 4, 4);
    repeat (3) @(posedge clk);
    #1;
    txf_afull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_rden_stall", int'(src_rden), 0);
      if (k > 0) chk("t3_wren_stall", int'(txf_wren), 0);
      @(posedge clk);
      #1;
    end
    txf_afull = 1'b0;
    @(negedge clk);
    chk("t3_wren_stall", int'(txf_wren), 0);
    wait_done("t3_done", 40);
    chk_glog("t3_grant", '{2});
    chk_wdat("t3_data", '{'h30, 'h31, 'h32, 'h33});

    // 4: 7-byte frame on source 1 truncated to 4, then source 2 normally.
    clear_logs();
    @(posedge clk); #1;
    push_frame(1, 'h10, 7, 7);
    push_frame(2, 'h40, 2, 2);
    wait_done("t4_done", 60);
    chk_glog("t4_order", '{1, 2});
    chk_wdat("t4_data", '{'h10, 'h11, 'h12, 'h13, 'h40, 'h41});
    chk("t4_trunc_count", ntrunc, 1);
    if (wlog_eod.size() == 6) begin
      chk("t4_eod_cut", wlog_eod[3], 1);
      chk("t4_eod_mid", wlog_eod[2], 0);
    end

    // 5: source 3 runs dry mid-frame for 10 cycles while source 0 waits.
    clear_logs();
    @(posedge clk); #1;
    push_frame(3, 'h50, 4, 2);
    push_frame(0, 'h60, 2, 2);
    repeat (4) @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_hold_valid", int'(grant_valid), 1);
      chk("t5_hold_idx", int'(grant_idx), 3);
    end
    @(posedge clk); #1;
    src_push(3, 'h52, 1'b0);
    src_push(3, 'h53, 1'b1);
    wait_done("t5_done", 60);
    chk_glog("t5_order", '{3, 0});
    chk_wdat("t5_data", '{'h50, 'h51, 'h52, 'h53, 'h60, 'h61});

    // 6: asynchronous reset during a source 2 transfer.
    clear_logs();
    @(posedge clk); #1;
    push_frame(2, 'h70, 4, 4);
    wait_writes("t6_started", 1, 40);
    @(negedge clk);
    #2;
    push_frame(1, 'h80, 2, 2);
    push_frame(3, 'h90, 2, 2);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    exp_q.delete();
    src_q[2].delete();
    model_q[2].delete();
    refresh();
    last_srv = N - 1;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    reset = 1'b0;
    wait_done("t6_done", 60);
    chk_glog("t6_order", '{1, 3});
    chk_wdat("t6_data", '{'h80, 'h81, 'h90, 'h91});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
